window_generator: RTL and testbench
===================================

Name: window_generator

Overview:
- Converts a raster-order pixel stream into a flattened window_width x window_width neighbourhood, one window per accepted pixel once the window is fully inside the image.
- Feeds MeanFilter and the other window-based filters in the preprocessing chain.
- out_data uses the same packing as the filters' in_data. out_ready drives the downstream filter's in_enable.
- Internal storage: window_width-1 line buffers plus a window_width x window_width register array.

Parameters:
color_width, 12, bits per pixel
window_width, 3, window side length; legal range 2..15
im_width, 320, pixels per image row; must be >= window_width
im_height, 240, rows per frame; must be >= window_width

Ports:
clk  input  1  system clock; all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
in_enable  input  1  in_data holds a valid pixel this cycle; accepted on posedge clk
in_data  input  color_width  pixel, raster order, row-major from (0,0)
out_ready  output  1  out_data holds a complete, valid window
out_data  output  color_width*window_width*window_width  flattened window

Behaviour:
- Reset (rst_n low, asynchronous): out_ready=0, out_data=0, col=0, row=0, window array cleared. Line-buffer contents need not be cleared.
- Acceptance: a pixel is accepted on each posedge with in_enable=1. With in_enable=0, all state holds (full stall), out_data holds, out_ready=0.
- Counters:
  - col increments per accepted pixel and wraps from im_width-1 to 0; row increments on that wrap.
  - row wraps from im_height-1 to 0, which starts a new frame. No gap between frames is needed.
- Line buffers:
  - Buffer k delays its input by exactly im_width accepted pixels.
  - Buffer 0 is fed by in_data; buffer k is fed by the output of buffer k-1.
  - Shifts happen only on acceptance.
- Window array:
  - On acceptance, each window row shifts left by one column.
  - Column window_width-1 loads, for window row r: r=window_width-1 takes in_data; r<window_width-1 takes the output of line buffer (window_width-2-r).
- Window contents: element (r,c) = pixel(row-(window_width-1-r), col-(window_width-1-c)), where (row,col) is the pixel just accepted.
- Packing: element index i = r*window_width + c occupies out_data[(i+1)*color_width-1 : i*color_width]. i=0 is the top-left (oldest) pixel; i=window_width^2-1 is the newest.
- Timing:
  - out_ready and out_data are registered and update on the edge that accepts the pixel.
  - Latency is 1 cycle from in_data presentation to the out_data visible after that edge.
  - out_ready is high for exactly one cycle per valid window.
- Validity: out_ready=1 after acceptance iff row>=window_width-1 and col>=window_width-1. No windows wrap across row edges or frame edges; there is no border padding.
- Windows per frame: (im_width-window_width+1)*(im_height-window_width+1).
- Reset mid-frame: all outputs clear immediately. The next accepted pixel is treated as (0,0) of a new frame.
- No backpressure: the downstream block must accept one window per cycle.

Decomposition:
- Shared package: full window size constant (window_width*window_width); clog2-derived widths for col and row counters; a function giving the bit offset of element i.
- One natural sub-module, line_buffer:
  - Parameters: color_width, depth=im_width.
  - Ports: clk, rst_n, in_enable, in_data, out_data.
  - Implemented as a circular RAM with a read/write pointer that advances on enable.
- window_generator instantiates window_width-1 line_buffer copies.

Test Plan (color_width=12, window_width=3, im_width=8, im_height=6; pixel value = row*16+col unless noted):
1. Assert rst_n=0 with in_enable=1 and arbitrary data -> out_ready=0 and out_data=0 throughout reset; the first pixel after release is treated as (0,0).
2. Stream frame 1 continuously -> first out_ready directly after acceptance of pixel (2,2), with element 0=0x000, element 4=0x011, element 8=0x022, element 2=0x002.
3. Full frame -> exactly 24 out_ready pulses. No pulse for col<2 or row<2. At (3,2): element 0=0x010 and element 8=0x032, with no previous-row tail mixed in.
4. Drop in_enable for 5 cycles after accepting (3,4), then resume -> out_ready=0 during the stall with out_data held at the (3,4) window. The following windows match an uninterrupted run.
5. Frame 2 back-to-back with values +0x100 -> first pulse at frame 2's (2,2), with element 0=0x100; no element takes a frame-1 value.
6. Pulse rst_n low for 1 cycle after accepting (3,5) -> outputs go to 0 asynchronously. The restarted stream gives its first out_ready at its own (2,2), with correct contents.

Source files
------------

// File: rtl/window_generator_pkg.sv
// Shared sizing helpers for the window generator and its line buffers.
// The default-geometry constants mirror the top-level parameter defaults.
package window_generator_pkg;

  localparam int DEF_COLOR_WIDTH  = 12;
  localparam int DEF_WINDOW_WIDTH = 3;
  localparam int DEF_IM_WIDTH     = 320;
  localparam int DEF_IM_HEIGHT    = 240;

  // Number of pixels held in one window.
  function automatic int win_size(input int ww);
    return ww * ww;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Bit offset of flattened window element i.
  function automatic int elem_offset(input int i, input int cw);
    return i * cw;
  endfunction

  localparam int DEF_WIN_SIZE = win_size(DEF_WINDOW_WIDTH);
  localparam int DEF_COL_W    = cnt_width(DEF_IM_WIDTH);
  localparam int DEF_ROW_W    = cnt_width(DEF_IM_HEIGHT);

endpackage

// File: rtl/window_generator_line_buffer.sv
// Circular-RAM delay line: out_data is the pixel written exactly depth
// enabled cycles earlier. Contents are not reset, only the pointer.
module line_buffer
  import window_generator_pkg::*;
#(
  parameter int color_width = 12,
  parameter int depth       = 320
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_enable,
  input  logic [color_width-1:0] in_data,
  output logic [color_width-1:0] out_data
);

  localparam int PTR_W = cnt_width(depth);

  logic [color_width-1:0] mem [depth];
  logic [PTR_W-1:0]       ptr_q;
  logic [PTR_W-1:0]       ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (in_enable) begin
      ptr_d = (ptr_q == PTR_W'(depth - 1)) ? '0 : ptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Read-before-write at the same slot gives the depth-old pixel.
  always_ff @(posedge clk) begin
    if (in_enable) begin
      mem[ptr_q] <= in_data;
    end
  end

  assign out_data = mem[ptr_q];

endmodule

// File: rtl/window_generator.sv
// Raster pixel stream to flattened window_width x window_width neighbourhood.
// Handshake: in_enable marks a valid pixel (no ready, never stalls upstream); out_ready pulses one cycle per complete window.
module window_generator
  import window_generator_pkg::*;
#(
  parameter int color_width  = DEF_COLOR_WIDTH,
  parameter int window_width = DEF_WINDOW_WIDTH,
  parameter int im_width     = DEF_IM_WIDTH,
  parameter int im_height    = DEF_IM_HEIGHT
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_enable,
  input  logic [color_width-1:0]                        in_data,
  output logic                                          out_ready,
  output logic [color_width*window_width*window_width-1:0] out_data
);

  localparam int WIN_SIZE = win_size(window_width);
  localparam int COL_W    = cnt_width(im_width);
  localparam int ROW_W    = cnt_width(im_height);
  localparam int LAST     = window_width - 1;

  logic [COL_W-1:0]       col_q, col_d;
  logic [ROW_W-1:0]       row_q, row_d;
  logic                   out_ready_q, out_ready_d;
  logic [color_width-1:0] win_q [window_width][window_width];
  logic [color_width-1:0] win_d [window_width][window_width];
  logic [color_width-1:0] lb_out [window_width-1];

  // Buffer 0 holds the previous image row; each further buffer one row older.
  for (genvar k = 0; k < window_width - 1; k++) begin : g_lb
    if (k == 0) begin : g_first
      line_buffer #(
        .color_width(color_width),
        .depth      (im_width)
      ) u_line_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_enable(in_enable),
        .in_data  (in_data),
        .out_data (lb_out[k])
      );
    end else begin : g_chain
      line_buffer #(
        .color_width(color_width),
        .depth      (im_width)
      ) u_line_buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_enable(in_enable),
        .in_data  (lb_out[k-1]),
        .out_data (lb_out[k])
      );
    end
  end

  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_d       = win_q;
    out_ready_d = 1'b0;
    if (in_enable) begin
      // Validity uses the coordinates of the pixel being accepted now.
      out_ready_d = (row_q >= ROW_W'(LAST)) && (col_q >= COL_W'(LAST));
      if (col_q == COL_W'(im_width - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(im_height - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      for (int r = 0; r < window_width; r++) begin
        for (int c = 0; c < LAST; c++) begin
          win_d[r][c] = win_q[r][c+1];
        end
      end
      for (int r = 0; r < LAST; r++) begin
        win_d[r][LAST] = lb_out[LAST-1-r];
      end
      win_d[LAST][LAST] = in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      out_ready_q <= 1'b0;
      for (int r = 0; r < window_width; r++) begin
        for (int c = 0; c < window_width; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      out_ready_q <= out_ready_d;
      win_q       <= win_d;
    end
  end

  // Element i = r*window_width + c; i = 0 is the oldest (top-left) pixel.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < WIN_SIZE; i++) begin
      out_data[elem_offset(i, color_width) +: color_width] =
        win_q[i / window_width][i % window_width];
    end
  end

  assign out_ready = out_ready_q;

endmodule

// File: tb/tb_window_generator.sv
// Bench for window_generator on an 8x6 image with 3x3 windows; expected
// windows come from a per-frame image array indexed by (row, col).
module tb_window_generator;

  localparam int CW = 12;
  localparam int WW = 3;
  localparam int IW = 8;
  localparam int IH = 6;
  localparam int DW = CW * WW * WW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_enable;
  logic [CW-1:0] in_data;
  logic          out_ready;
  logic [DW-1:0] out_data;

  window_generator #(
    .color_width (CW),
    .window_width(WW),
    .im_width    (IW),
    .im_height   (IH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_enable(in_enable),
    .in_data  (in_data),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [DW-1:0] exp_q[$];
  logic [CW-1:0] img [IH][IW];
  int            m_row, m_col;
  int            acc_row, acc_col;
  logic          last_valid;
  logic [DW-1:0] last_win;
  int            n_checks = 0;
  int            n_bad    = 0;
  int            pulses;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] elem(input logic [DW-1:0] d, input int i);
    return d[i*CW +: CW];
  endfunction

  // Window around (row,col): element (r,c) = pixel(row-(WW-1-r), col-(WW-1-c)).
  function automatic logic [DW-1:0] model_window(input int row, input int col);
    logic [DW-1:0] w;
    w = '0;
    for (int r = 0; r < WW; r++)
      for (int c = 0; c < WW; c++)
        w[(r*WW + c)*CW +: CW] = img[row-(WW-1-r)][col-(WW-1-c)];
    return w;
  endfunction

  function automatic void model_reset();
    m_row = 0;
    m_col = 0;
    last_valid = 1'b0;
    exp_q.delete();
  endfunction

  // ---------------- driver tasks ----------------
  task automatic push_pixel(input logic [CW-1:0] v);
    logic          exp_ready;
    logic [DW-1:0] w;
    in_enable = 1'b1;
    in_data   = v;
    @(posedge clk);
    #1;
    img[m_row][m_col] = v;
    exp_ready = (m_row >= WW-1) && (m_col >= WW-1);
    w = '0;
    if (exp_ready) begin
      w = model_window(m_row, m_col);
      exp_q.push_back(w);
    end
    check("ready", DW'(out_ready), DW'(exp_ready));
    if (out_ready) pulses++;
    if (exp_q.size() > 0) check("window", out_data, exp_q.pop_front());
    last_valid = exp_ready;
    if (exp_ready) last_win = w;
    acc_row = m_row;
    acc_col = m_col;
    if (m_col == IW-1) begin
      m_col = 0;
      m_row = (m_row == IH-1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic stall(input int n);
    in_enable = 1'b0;
    for (int k = 0; k < n; k++) begin
      in_data = CW'($urandom);
      @(posedge clk);
      #1;
      check("stall_ready", DW'(out_ready), '0);
      if (last_valid) check("stall_hold", out_data, last_win);
    end
  endtask

  // mode 1: pattern frame with spot checks and a 5-cycle stall at (3,4)
  // mode 2: pattern +0x100, mode 3: abort after (3,5), mode 4: random data/stalls
  task automatic run_frame(input int mode, input logic [CW-1:0] base);
    logic [CW-1:0] v;
    pulses = 0;
    for (int r = 0; r < IH; r++) begin
      for (int c = 0; c < IW; c++) begin
        v = (mode == 4) ? CW'($urandom) : base + CW'(r*16 + c);
        push_pixel(v);
        if (mode == 1 && acc_row == 2 && acc_col == 2) begin
          check("f1_22_e0", DW'(elem(out_data, 0)), DW'(12'h000));
          check("f1_22_e2", DW'(elem(out_data, 2)), DW'(12'h002));
          check("f1_22_e4", DW'(elem(out_data, 4)), DW'(12'h011));
          check("f1_22_e8", DW'(elem(out_data, 8)), DW'(12'h022));
        end
        if (mode == 1 && acc_row == 3 && acc_col == 2) begin
          check("f1_32_e0", DW'(elem(out_data, 0)), DW'(12'h010));
          check("f1_32_e8", DW'(elem(out_data, 8)), DW'(12'h032));
        end
        if (mode == 1 && acc_row == 3 && acc_col == 4) stall(5);
        if (mode == 2 && acc_row == 2 && acc_col == 2)
          check("f2_22_e0", DW'(elem(out_data, 0)), DW'(12'h100));
        if (mode == 3 && acc_row == 3 && acc_col == 5) return;
        if (mode == 4 && $urandom_range(0, 3) == 0) stall($urandom_range(1, 3));
      end
    end
    check("pulses", DW'(pulses), DW'((IW-WW+1)*(IH-WW+1)));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    last_win  = '0;
    rst_n     = 1'b0;
    in_enable = 1'b1;
    in_data   = CW'($urandom);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      in_data = CW'($urandom);
      check("rst_ready", DW'(out_ready), '0);
      check("rst_data", out_data, '0);
    end
    rst_n = 1'b1;

    run_frame(1, 12'h000);
    run_frame(2, 12'h100);
    run_frame(3, 12'h200);

    // Mid-frame reset pulse: outputs must clear before the next edge.
    rst_n = 1'b0;
    #1;
    check("async_ready", DW'(out_ready), '0);
    check("async_data", out_data, '0);
    in_enable = 1'b1;
    in_data   = CW'($urandom);
    @(posedge clk);
    #1;
    check("hold_rst_ready", DW'(out_ready), '0);
    check("hold_rst_data", out_data, '0);
    rst_n = 1'b1;
    model_reset();

    run_frame(1, 12'h000);
    run_frame(4, 12'h000);
    run_frame(4, 12'h000);
    run_frame(2, 12'h100);

    in_enable = 1'b0;
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
